// File: rtl/cmin_pkg.sv
// cmin_pkg
// Shared definitions for the compute-macro input feeder and the activation
// buffer writer: lane geometry, width helpers, reset configuration values and
// the bit-plane extraction function.
package cmin_pkg;

  // Width helpers. idx_bits never returns 0 so that a 1-bit-per-lane build
  // still has a legal index vector.
  function automatic int clog2(input int value);
    return $clog2(value);
  endfunction

  function automatic int idx_bits(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Lane geometry is fixed here because the activation-buffer writer packs
  // vectors with the same layout and calls get_plane as well.
  localparam int CMIN_LANES    = 16;
  localparam int CMIN_MAX_PREC = 8;
  localparam int CMIN_REPL     = 288;
  localparam int CMIN_ADDR_W   = 8;

  localparam int CMIN_VEC_W = CMIN_LANES * CMIN_MAX_PREC;
  localparam int PREC_W     = clog2(CMIN_MAX_PREC) + 1;
  localparam int IDX_W      = idx_bits(CMIN_MAX_PREC);

  typedef logic [CMIN_VEC_W-1:0] vec_t;
  typedef logic [CMIN_LANES-1:0] plane_t;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_e;

  localparam logic [PREC_W-1:0] DEF_PREC  = PREC_W'(CMIN_MAX_PREC);
  localparam bit_order_e        DEF_ORDER = MSB_FIRST;

  // Out-of-range precision requests fall back to full precision.
  function automatic logic [PREC_W-1:0] clamp_prec(input logic [PREC_W-1:0] prec);
    if (prec == '0 || prec > PREC_W'(CMIN_MAX_PREC)) begin
      return PREC_W'(CMIN_MAX_PREC);
    end
    return prec;
  endfunction

  // Gather bit idx of every lane; lane i lives in vec[i*MAX_PREC +: MAX_PREC].
  function automatic plane_t get_plane(input vec_t vec, input logic [IDX_W-1:0] idx);
    plane_t                   plane;
    logic [CMIN_MAX_PREC-1:0] lane;
    plane = '0;
    for (int i = 0; i < CMIN_LANES; i++) begin
      lane     = vec[i*CMIN_MAX_PREC +: CMIN_MAX_PREC];
      plane[i] = lane[idx];
    end
    return plane;
  endfunction

endpackage

// File: rtl/cmin_vec_buf.sv
// cmin_vec_buf
// Two-entry FIFO holding whole activation vectors. The full flag is a
// register so the upstream ready never depends on the macro-side handshake.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   push      write wr_data into the tail (caller guarantees ~full)
//   wr_data   vector to store
//   pop       drop the head entry (caller guarantees count != 0)
//   rd_data   head entry (undefined content when empty)
//   count     number of stored entries, 0..2
//   full      registered count == 2
module cmin_vec_buf #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count_q;
  logic [1:0]       count_next;
  logic             full_q;

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + 2'd1;
    end else if (pop && !push) begin
      count_next = count_q - 2'd1;
    end
  end

  // Storage needs no reset: the head is only looked at while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
      full_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_next;
      full_q  <= (count_next == 2'd2);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: rtl/cmin_bitserial_feeder.sv
// cmin_bitserial_feeder
// Buffers activation vectors and streams them one bit-plane per accepted
// transfer into the NMC macro array, together with a row address that walks a
// programmable window. Lane geometry (16 lanes x 8 bits) comes from cmin_pkg.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_load        latch cfg_* when idle (ignored while busy)
//   cfg_prec        bits per lane, 0 or >MAX_PREC means MAX_PREC
//   cfg_msb_first   1: highest bit first, 0: bit 0 first
//   cfg_addr_base   first row of the address window
//   cfg_addr_len    rows in the window, 0 means 1
//   data_in/_vld/_rdy  vector input handshake, ready is registered
//   data_in_update  pulse when the last plane of a vector is accepted
//   nmc_addr        row address of the vector being streamed
//   nmc_cmIn        current plane replicated REPL times
//   nmc_cmIn_vld/_rdy  plane handshake towards the macro
//   nmc_last_bit    current plane is the last one of its vector
//   busy            a vector is buffered or in flight
module cmin_bitserial_feeder
  import cmin_pkg::*;
#(
  parameter int REPL   = CMIN_REPL,
  parameter int ADDR_W = CMIN_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_load,
  input  logic [PREC_W-1:0]          cfg_prec,
  input  logic                       cfg_msb_first,
  input  logic [ADDR_W-1:0]          cfg_addr_base,
  input  logic [ADDR_W-1:0]          cfg_addr_len,
  input  logic [CMIN_VEC_W-1:0]      data_in,
  input  logic                       data_in_vld,
  output logic                       data_in_rdy,
  output logic                       data_in_update,
  output logic [ADDR_W-1:0]          nmc_addr,
  output logic [CMIN_LANES*REPL-1:0] nmc_cmIn,
  output logic                       nmc_cmIn_vld,
  input  logic                       nmc_cmIn_rdy,
  output logic                       nmc_last_bit,
  output logic                       busy
);

  logic [PREC_W-1:0] prec_q;
  bit_order_e        order_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_end;
  logic [ADDR_W-1:0] addr_next;
  logic [IDX_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  plane_idx;
  logic [1:0]        count;
  logic              full;
  vec_t              head;
  plane_t            plane;
  logic              push;
  logic              pop;
  logic              fire;
  logic              last_plane;

  cmin_vec_buf #(
    .WIDTH(CMIN_VEC_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (data_in),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full)
  );

  assign push         = data_in_vld & ~full;
  assign nmc_cmIn_vld = (count != 2'd0);
  assign fire         = nmc_cmIn_vld & nmc_cmIn_rdy;
  assign last_plane   = nmc_cmIn_vld & (PREC_W'(bit_cnt) == prec_q - PREC_W'(1));
  assign pop          = fire & last_plane;

  // Gating with rst keeps a vector cut off by reset from reporting completion.
  assign data_in_update = pop & ~rst;
  assign data_in_rdy    = ~full;
  assign busy           = nmc_cmIn_vld | (bit_cnt != '0);
  assign nmc_last_bit   = last_plane;
  assign nmc_addr       = addr_q;

  // MSB-first counts down from prec-1; the difference always fits in IDX_W.
  assign plane_idx = (order_q == MSB_FIRST)
                   ? IDX_W'(prec_q - PREC_W'(1) - PREC_W'(bit_cnt))
                   : bit_cnt;
  assign plane    = nmc_cmIn_vld ? get_plane(head, plane_idx) : '0;
  assign nmc_cmIn = {REPL{plane}};

  // Window end is computed modulo 2**ADDR_W so a window may wrap past the top.
  assign addr_end  = base_q + len_q - ADDR_W'(1);
  assign addr_next = (addr_q == addr_end) ? base_q : addr_q + ADDR_W'(1);

  // cfg_load and a pop can never coincide: a pop needs a buffered vector,
  // which means busy, which blocks the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      prec_q  <= DEF_PREC;
      order_q <= DEF_ORDER;
      base_q  <= '0;
      len_q   <= '1;
      addr_q  <= '0;
      bit_cnt <= '0;
    end else begin
      if (cfg_load && !busy) begin
        prec_q  <= clamp_prec(cfg_prec);
        order_q <= bit_order_e'(cfg_msb_first);
        base_q  <= cfg_addr_base;
        len_q   <= (cfg_addr_len == '0) ? ADDR_W'(1) : cfg_addr_len;
        addr_q  <= cfg_addr_base;
      end
      if (fire) begin
        if (last_plane) begin
          bit_cnt <= '0;
          addr_q  <= addr_next;
        end else begin
          bit_cnt <= bit_cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmin_bitserial_feeder.sv
// tb_cmin_bitserial_feeder
// Drives the feeder with directed scenarios followed by randomized traffic and
// compares every output, every cycle, against a queue-based reference model.
module tb_cmin_bitserial_feeder;
  import cmin_pkg::*;

  localparam int LANES    = CMIN_LANES;
  localparam int MAX_PREC = CMIN_MAX_PREC;
  localparam int REPL     = CMIN_REPL;
  localparam int ADDR_W   = CMIN_ADDR_W;
  localparam int VEC_W    = CMIN_VEC_W;

  logic                   clk;
  logic                   rst;
  logic                   cfg_load;
  logic [PREC_W-1:0]      cfg_prec;
  logic                   cfg_msb_first;
  logic [ADDR_W-1:0]      cfg_addr_base;
  logic [ADDR_W-1:0]      cfg_addr_len;
  logic [VEC_W-1:0]       data_in;
  logic                   data_in_vld;
  logic                   data_in_rdy;
  logic                   data_in_update;
  logic [ADDR_W-1:0]      nmc_addr;
  logic [LANES*REPL-1:0]  nmc_cmIn;
  logic                   nmc_cmIn_vld;
  logic                   nmc_cmIn_rdy;
  logic                   nmc_last_bit;
  logic                   busy;

  cmin_bitserial_feeder #(
    .REPL   (REPL),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_load       (cfg_load),
    .cfg_prec       (cfg_prec),
    .cfg_msb_first  (cfg_msb_first),
    .cfg_addr_base  (cfg_addr_base),
    .cfg_addr_len   (cfg_addr_len),
    .data_in        (data_in),
    .data_in_vld    (data_in_vld),
    .data_in_rdy    (data_in_rdy),
    .data_in_update (data_in_update),
    .nmc_addr       (nmc_addr),
    .nmc_cmIn       (nmc_cmIn),
    .nmc_cmIn_vld   (nmc_cmIn_vld),
    .nmc_cmIn_rdy   (nmc_cmIn_rdy),
    .nmc_last_bit   (nmc_last_bit),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered vectors in arrival order, the index of the
  // plane being presented for the head vector, the active configuration and
  // the row address of the head vector.
  logic [VEC_W-1:0] mq[$];
  int               m_k;
  int               m_prec;
  bit               m_msb;
  int               m_base;
  int               m_len;
  int               m_addr;
  int               upd_cnt;
  int               fire_cnt;
  int               upd_addrs[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mq.delete();
    m_k    = 0;
    m_prec = MAX_PREC;
    m_msb  = 1'b1;
    m_base = 0;
    m_len  = (1 << ADDR_W) - 1;
    m_addr = 0;
  endfunction

  // Plane k of a vector holds, for every lane, bit (prec-1-k) when streaming
  // MSB first or bit k otherwise.
  function automatic plane_t modelPlane();
    plane_t           p;
    logic [VEC_W-1:0] v;
    logic [VEC_W-1:0] shifted;
    int               bitpos;
    p = '0;
    if (mq.size() == 0) return p;
    v      = mq[0];
    bitpos = m_msb ? (m_prec - 1 - m_k) : m_k;
    for (int i = 0; i < LANES; i++) begin
      shifted = v >> (i * MAX_PREC + bitpos);
      p[i]    = shifted[0];
    end
    return p;
  endfunction

  function automatic int windowNext(input int addr);
    int offset;
    offset = (addr - m_base + (1 << ADDR_W)) % (1 << ADDR_W);
    return (m_base + (offset + 1) % m_len) % (1 << ADDR_W);
  endfunction

  function automatic logic [VEC_W-1:0] randVec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int updAddr(input int n);
    return (upd_addrs.size() > n) ? upd_addrs[n] : -1;
  endfunction

  // One clock cycle: called at a falling edge with inputs already driven.
  // Checks all outputs, advances the model with the inputs the DUT will
  // sample at the next rising edge, then waits for the next falling edge.
  task automatic applyStimulus();
    plane_t                ep;
    logic [LANES*REPL-1:0] ef;
    bit                    m_vld;
    bit                    m_last;
    bit                    m_fire;
    bit                    m_push;
    int                    p;
    #1;
    m_vld  = (mq.size() > 0);
    m_last = m_vld && (m_k == m_prec - 1);
    m_fire = m_vld && nmc_cmIn_rdy;
    ep     = modelPlane();
    ef     = {REPL{ep}};
    checkOutput("data_in_rdy", 64'(data_in_rdy), 64'(mq.size() < 2));
    checkOutput("nmc_cmIn_vld", 64'(nmc_cmIn_vld), 64'(m_vld));
    checkOutput("nmc_addr", 64'(nmc_addr), 64'(m_addr));
    checkOutput("nmc_last_bit", 64'(nmc_last_bit), 64'(m_last));
    checkOutput("busy", 64'(busy), 64'(m_vld));
    checkOutput("plane", 64'(nmc_cmIn[LANES-1:0]), 64'(ep));
    checkOutput("cmIn_repl", 64'(nmc_cmIn == ef), 64'd1);
    checkOutput("data_in_update", 64'(data_in_update), 64'(!rst && m_fire && m_last));
    if (rst) begin
      modelReset();
    end else begin
      m_push = data_in_vld && (mq.size() < 2);
      if (cfg_load && !m_vld) begin
        p      = int'(cfg_prec);
        m_prec = (p == 0 || p > MAX_PREC) ? MAX_PREC : p;
        m_msb  = cfg_msb_first;
        m_base = int'(cfg_addr_base);
        m_len  = (cfg_addr_len == '0) ? 1 : int'(cfg_addr_len);
        m_addr = m_base;
      end
      if (m_fire) begin
        fire_cnt++;
        if (m_last) begin
          upd_cnt++;
          upd_addrs.push_back(m_addr);
          void'(mq.pop_front());
          m_k    = 0;
          m_addr = windowNext(m_addr);
        end else begin
          m_k++;
        end
      end
      if (m_push) mq.push_back(data_in);
    end
    @(negedge clk);
  endtask

  task automatic idleInputs();
    rst         = 1'b0;
    cfg_load    = 1'b0;
    data_in_vld = 1'b0;
    nmc_cmIn_rdy = 1'b0;
  endtask

  task automatic loadCfg(input int prec, input bit msb, input int base, input int len);
    idleInputs();
    cfg_load      = 1'b1;
    cfg_prec      = PREC_W'(prec);
    cfg_msb_first = msb;
    cfg_addr_base = ADDR_W'(base);
    cfg_addr_len  = ADDR_W'(len);
    applyStimulus();
    cfg_load = 1'b0;
  endtask

  task automatic drain(input string tag);
    data_in_vld  = 1'b0;
    nmc_cmIn_rdy = 1'b1;
    for (int c = 0; c < 64 && busy; c++) applyStimulus();
    checkOutput(tag, 64'(busy), 64'd0);
  endtask

  task automatic clearStats();
    upd_cnt  = 0;
    fire_cnt = 0;
    upd_addrs.delete();
  endtask

  initial begin
    logic [VEC_W-1:0] vec_a;
    int               pushed;

    idleInputs();
    rst           = 1'b1;
    cfg_prec      = '0;
    cfg_msb_first = 1'b0;
    cfg_addr_base = '0;
    cfg_addr_len  = '0;
    data_in       = '0;
    repeat (2) @(negedge clk);
    modelReset();
    clearStats();
    #1;
    checkOutput("rst_rdy", 64'(data_in_rdy), 64'd1);
    checkOutput("rst_vld", 64'(nmc_cmIn_vld), 64'd0);
    checkOutput("rst_update", 64'(data_in_update), 64'd0);
    checkOutput("rst_last", 64'(nmc_last_bit), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_addr", 64'(nmc_addr), 64'd0);
    checkOutput("rst_cmIn_zero", 64'(nmc_cmIn == '0), 64'd1);
    @(negedge clk);

    $display("[TB] default cfg, vectors A and ~A");
    for (int i = 0; i < LANES; i++) vec_a[i*MAX_PREC +: MAX_PREC] = MAX_PREC'(i);
    idleInputs();
    nmc_cmIn_rdy = 1'b1;
    data_in_vld  = 1'b1;
    data_in      = vec_a;
    applyStimulus();
    data_in      = ~vec_a;
    applyStimulus();
    drain("p1_drain");
    checkOutput("p1_updates", 64'(upd_cnt), 64'd2);
    checkOutput("p1_planes", 64'(fire_cnt), 64'd16);
    checkOutput("p1_addr0", 64'(updAddr(0)), 64'd0);
    checkOutput("p1_addr1", 64'(updAddr(1)), 64'd1);
    checkOutput("p1_addr_end", 64'(nmc_addr), 64'd2);

    $display("[TB] prec 3, LSB first, window 5..6");
    loadCfg(3, 1'b0, 5, 2);
    clearStats();
    pushed = 0;
    for (int c = 0; c < 40 && (pushed < 3 || busy); c++) begin
      nmc_cmIn_rdy = 1'b1;
      data_in_vld  = (pushed < 3);
      data_in      = randVec();
      if (data_in_vld && data_in_rdy) pushed++;
      applyStimulus();
    end
    data_in_vld = 1'b0;
    checkOutput("p2_updates", 64'(upd_cnt), 64'd3);
    checkOutput("p2_planes", 64'(fire_cnt), 64'd9);
    checkOutput("p2_addr0", 64'(updAddr(0)), 64'd5);
    checkOutput("p2_addr1", 64'(updAddr(1)), 64'd6);
    checkOutput("p2_addr2", 64'(updAddr(2)), 64'd5);

    $display("[TB] stall mid-vector");
    loadCfg(8, 1'b1, 16, 4);
    clearStats();
    nmc_cmIn_rdy = 1'b1;
    data_in_vld  = 1'b1;
    data_in      = randVec();
    applyStimulus();
    data_in_vld = 1'b0;
    repeat (3) applyStimulus();
    nmc_cmIn_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      data_in_vld = 1'b1;
      data_in     = randVec();
      applyStimulus();
    end
    checkOutput("p3_rdy_full", 64'(data_in_rdy), 64'd0);
    checkOutput("p3_frozen_planes", 64'(fire_cnt), 64'd3);
    drain("p3_drain");
    checkOutput("p3_updates", 64'(upd_cnt), 64'd2);
    checkOutput("p3_addr1", 64'(updAddr(1)), 64'd17);

    $display("[TB] prec 1 streaming");
    loadCfg(1, 1'b1, 0, 8);
    clearStats();
    nmc_cmIn_rdy = 1'b1;
    for (int c = 0; c < 20; c++) begin
      data_in_vld = 1'b1;
      data_in     = randVec();
      applyStimulus();
    end
    drain("p4_drain");
    checkOutput("p4_updates", 64'(upd_cnt), 64'd20);
    checkOutput("p4_addr7", 64'(updAddr(7)), 64'd7);
    checkOutput("p4_addr8", 64'(updAddr(8)), 64'd0);
    checkOutput("p4_addr_end", 64'(nmc_addr), 64'd4);

    $display("[TB] cfg_load while busy");
    loadCfg(8, 1'b0, 0, 4);
    data_in_vld = 1'b1;
    data_in     = randVec();
    applyStimulus();
    clearStats();
    data_in_vld   = 1'b0;
    nmc_cmIn_rdy  = 1'b1;
    cfg_load      = 1'b1;
    cfg_prec      = PREC_W'(2);
    cfg_msb_first = 1'b1;
    cfg_addr_base = ADDR_W'(7);
    cfg_addr_len  = ADDR_W'(3);
    applyStimulus();
    cfg_load = 1'b0;
    drain("p5_drain");
    checkOutput("p5_planes_busy_load", 64'(fire_cnt), 64'd8);
    checkOutput("p5_addr", 64'(nmc_addr), 64'd1);
    loadCfg(2, 1'b1, 7, 3);
    clearStats();
    data_in_vld = 1'b1;
    data_in     = randVec();
    applyStimulus();
    drain("p5_drain2");
    checkOutput("p5_planes_idle_load", 64'(fire_cnt), 64'd2);
    checkOutput("p5_addr2", 64'(nmc_addr), 64'd8);

    $display("[TB] reset mid-vector");
    loadCfg(8, 1'b1, 3, 5);
    clearStats();
    nmc_cmIn_rdy = 1'b1;
    data_in_vld  = 1'b1;
    data_in      = randVec();
    applyStimulus();
    data_in_vld = 1'b0;
    repeat (4) applyStimulus();
    checkOutput("p6_planes_before_rst", 64'(fire_cnt), 64'd4);
    rst = 1'b1;
    applyStimulus();
    rst          = 1'b0;
    nmc_cmIn_rdy = 1'b0;
    #1;
    checkOutput("p6_vld", 64'(nmc_cmIn_vld), 64'd0);
    checkOutput("p6_addr", 64'(nmc_addr), 64'd0);
    checkOutput("p6_rdy", 64'(data_in_rdy), 64'd1);
    checkOutput("p6_busy", 64'(busy), 64'd0);
    checkOutput("p6_no_update", 64'(upd_cnt), 64'd0);
    @(negedge clk);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      cfg_load      = ($urandom_range(0, 15) == 0);
      cfg_prec      = PREC_W'($urandom_range(0, (1 << PREC_W) - 1));
      cfg_msb_first = 1'($urandom);
      cfg_addr_base = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(250, 255))
                                                  : ADDR_W'($urandom);
      cfg_addr_len  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom)
                                                  : ADDR_W'($urandom_range(0, 12));
      data_in_vld   = ($urandom_range(0, 9) < 7);
      data_in       = randVec();
      nmc_cmIn_rdy  = ($urandom_range(0, 9) < 7);
      applyStimulus();
    end
    idleInputs();
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
